// File: rtl/raw_buffer_fence_ctrl.sv
// Raw hits buffer allocator: grants event space, pushes {tag,adr} fences, pops on readout; ack 2 cycles after request, 2-cycle settle after push/pop.
// Optional RAW_FENCE_DENY_CNT_EN adds a saturating deny counter output (deny_cnt).
module raw_buffer_fence_ctrl #(
   parameter int ADRB    = 11,
   parameter int MXADR   = 2048,
   parameter int MINFREE = 64
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               evt_req,
   input  logic [ADRB-1:0]    evt_len,
   input  logic [31:0]        evt_tag,
   output logic               evt_ack,
   output logic               evt_ok,
   output logic [ADRB-1:0]    evt_adr,
   input  logic               rd_done,
   output logic               fq_push,
   output logic [ADRB+31:0]   fq_wr_data,
   output logic               fq_pop,
   input  logic [ADRB+31:0]   fq_rd_data,
   input  logic               fq_full,
   input  logic               fq_empty,
   output logic [ADRB-1:0]    wr_ptr,
   output logic [ADRB:0]      free_space,
   output logic               buf_busy,
   output logic [31:0]        oldest_tag,
   output logic               udf_err
`ifdef RAW_FENCE_DENY_CNT_EN
   ,
   output logic [15:0]        deny_cnt
`endif
);

   localparam logic [ADRB:0] MXADR_W   = (ADRB+1)'(MXADR);
   localparam logic [ADRB:0] MINFREE_W = (ADRB+1)'(MINFREE);

   typedef enum logic [1:0] {IDLE, CHECK, ACK} state_t;

   state_t            state, state_nx;
   logic [1:0]        settle;
   logic              grant_q;
   logic [ADRB-1:0]   len_q;
   logic [31:0]       tag_q;

   // An empty queue means nothing is held; otherwise zero difference means full.
   assign free_space = fq_empty ? MXADR_W
                                : {1'b0, fq_rd_data[ADRB-1:0] - wr_ptr};
   assign buf_busy   = (free_space < MINFREE_W) || fq_full;
   assign oldest_tag = fq_rd_data[ADRB+31:ADRB];
   assign fq_pop     = rd_done && !fq_empty;
   assign fq_wr_data = {tag_q, wr_ptr};

   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         settle  <= 2'd0;
         wr_ptr  <= '0;
         grant_q <= 1'b0;
         len_q   <= '0;
         tag_q   <= '0;
         udf_err <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == CHECK) begin
            grant_q <= (evt_len != '0) && ({1'b0, evt_len} <= free_space) && !fq_full;
            len_q   <= evt_len;
            tag_q   <= evt_tag;
         end
         if (state == ACK && grant_q)
            wr_ptr <= wr_ptr + len_q;
         // Hold off new decisions until the queue outputs reflect the last push/pop.
         if (fq_pop || state == ACK)
            settle <= 2'd2;
         else if (settle != 2'd0)
            settle <= settle - 2'd1;
         if (rd_done && fq_empty)
            udf_err <= 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      evt_ack  = 1'b0;
      evt_ok   = 1'b0;
      fq_push  = 1'b0;
      evt_adr  = '0;
      case (state)
         IDLE:    if (settle == 2'd0 && evt_req) state_nx = CHECK;
         CHECK:   state_nx = ACK;
         ACK: begin
            evt_ack  = 1'b1;
            evt_ok   = grant_q;
            fq_push  = grant_q;
            if (grant_q) evt_adr = wr_ptr;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

`ifdef RAW_FENCE_DENY_CNT_EN
   always_ff @(posedge clock) begin
      if (reset)
         deny_cnt <= 16'd0;
      else if (state == ACK && !grant_q && deny_cnt != 16'hFFFF)
         deny_cnt <= deny_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_raw_buffer_fence_ctrl.sv
// Bench for raw_buffer_fence_ctrl: behavioural fence queue, directed cases then random traffic vs a queue-based model.
module tb_raw_buffer_fence_ctrl;
   localparam int ADRB = 11;
   localparam int FQD  = 8;

   logic clock, reset, evt_req, evt_ack, evt_ok, rd_done, fq_push, fq_pop, fq_full, fq_empty, buf_busy, udf_err;
   logic [ADRB-1:0] evt_len, evt_adr, wr_ptr;
   logic [31:0] evt_tag, oldest_tag;
   logic [ADRB+31:0] fq_wr_data, fq_rd_data;
   logic [ADRB:0] free_space;
`ifdef RAW_FENCE_DENY_CNT_EN
   logic [15:0] deny_cnt;
`endif

   raw_buffer_fence_ctrl #(.ADRB(ADRB), .MXADR(2048), .MINFREE(64)) dut (
      .clock(clock), .reset(reset), .evt_req(evt_req), .evt_len(evt_len), .evt_tag(evt_tag),
      .evt_ack(evt_ack), .evt_ok(evt_ok), .evt_adr(evt_adr), .rd_done(rd_done),
      .fq_push(fq_push), .fq_wr_data(fq_wr_data), .fq_pop(fq_pop), .fq_rd_data(fq_rd_data),
      .fq_full(fq_full), .fq_empty(fq_empty), .wr_ptr(wr_ptr), .free_space(free_space),
      .buf_busy(buf_busy), .oldest_tag(oldest_tag), .udf_err(udf_err)
`ifdef RAW_FENCE_DENY_CNT_EN
      , .deny_cnt(deny_cnt)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Fence queue stand-in
   logic [ADRB+31:0] fq_mem [FQD];
   logic [2:0] fq_rp, fq_wp;
   logic [3:0] fq_cnt;
   assign fq_rd_data = fq_mem[fq_rp];
   assign fq_empty   = (fq_cnt == 4'd0);
   assign fq_full    = (fq_cnt == 4'(FQD));
   always @(posedge clock) begin
      if (reset) begin
         fq_rp <= '0; fq_wp <= '0; fq_cnt <= '0;
      end else begin
         if (fq_push) begin fq_mem[fq_wp] <= fq_wr_data; fq_wp <= fq_wp + 3'd1; end
         if (fq_pop) fq_rp <= fq_rp + 3'd1;
         fq_cnt <= fq_cnt + 4'(fq_push) - 4'(fq_pop);
      end
   end

   // Reference model
   typedef struct packed { logic [31:0] tag; logic [ADRB-1:0] adr; } fence_t;
   typedef struct { bit ok; logic [ADRB-1:0] adr; logic [31:0] tag; } exp_t;
   fence_t fence_q[$];
   exp_t   sb_q[$];
   logic [ADRB-1:0] mwr;
   bit     mudf;
   int     mdeny;
   int     checks = 0, failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int model_free();
      if (fence_q.size() == 0) return 2048;
      return int'((fence_q[0].adr - mwr) & 11'h7FF);
   endfunction

   always @(negedge clock) begin
      if (!reset && evt_ack) begin
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_ack act=1 exp=0 t=%0t", $time);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("evt_ok", 64'(evt_ok), 64'(e.ok));
            chk("fq_push", 64'(fq_push), 64'(e.ok));
            if (e.ok) begin
               chk("evt_adr", 64'(evt_adr), 64'(e.adr));
               chk("fq_wr_data", 64'(fq_wr_data), 64'({e.tag, e.adr}));
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; evt_req = 1'b0; rd_done = 1'b0; evt_len = '0; evt_tag = '0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      fence_q.delete(); sb_q.delete();
      mwr = '0; mudf = 0; mdeny = 0;
      chk("rst_wr_ptr", 64'(wr_ptr), 64'd0);
      chk("rst_free", 64'(free_space), 64'd2048);
      chk("rst_busy", 64'(buf_busy), 64'd0);
      chk("rst_ack", 64'({evt_ack, fq_push, fq_pop}), 64'd0);
      chk("rst_udf", 64'(udf_err), 64'd0);
   endtask

   task automatic do_req(input logic [ADRB-1:0] len, input logic [31:0] tag, input bit with_rd);
      bit ok, seen;
      int lat;
      ok = (len != 0) && (int'(len) <= model_free()) && (fence_q.size() < FQD);
      sb_q.push_back('{ok, mwr, tag});
      @(negedge clock);
      evt_req = 1'b1; evt_len = len; evt_tag = tag;
      seen = 0; lat = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clock);
         if (evt_ack) begin seen = 1; lat = i; end
      end
      evt_req = 1'b0;
      if (!seen) begin
         failures++;
         $display("FAIL ack_timeout act=none exp=ack t=%0t", $time);
         void'(sb_q.pop_back());
         return;
      end
      chk("ack_latency", 64'(lat), 64'd1);
      if (with_rd) begin
         rd_done = 1'b1;
         #1 chk("coincide_pop", 64'(fq_pop), 64'(fence_q.size() != 0));
         if (fence_q.size() != 0) void'(fence_q.pop_front()); else mudf = 1;
         @(negedge clock);
         rd_done = 1'b0;
      end
      if (ok) begin
         fence_q.push_back('{tag, mwr});
         mwr = mwr + len;
      end else if (mdeny < 16'hFFFF) mdeny++;
      repeat (3) @(negedge clock);
   endtask

   task automatic do_rd();
      @(negedge clock);
      rd_done = 1'b1;
      #1 chk("fq_pop", 64'(fq_pop), 64'(fence_q.size() != 0));
      if (fence_q.size() != 0) void'(fence_q.pop_front()); else mudf = 1;
      @(negedge clock);
      rd_done = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   task automatic check_state(input string nm);
      int f;
      f = model_free();
      chk({nm, "_wr_ptr"}, 64'(wr_ptr), 64'(mwr));
      chk({nm, "_free"}, 64'(free_space), 64'(f));
      chk({nm, "_busy"}, 64'(buf_busy), 64'((f < 64) || (fence_q.size() == FQD)));
      chk({nm, "_udf"}, 64'(udf_err), 64'(mudf));
      if (fence_q.size() != 0) chk({nm, "_oldest_tag"}, 64'(oldest_tag), 64'(fence_q[0].tag));
   endtask

   initial begin
      reset = 1'b1; evt_req = 1'b0; rd_done = 1'b0; evt_len = '0; evt_tag = '0;
      do_reset();

      do_req(11'd100, 32'hA5, 0);
      check_state("first");

      do_reset();
      do_req(11'd2040, 32'h1, 0);
      do_req(11'd9, 32'h2, 0);
      check_state("deny9");
      do_rd();
      do_req(11'd9, 32'h3, 0);
      check_state("wrap");

      do_reset();
      do_rd();
      check_state("udf");
      do_req(11'd100, 32'h10, 0);
      do_req(11'd1948, 32'h11, 0);
      check_state("full");
      do_req(11'd1, 32'h12, 0);
      check_state("full_deny");

      do_reset();
      do_req(11'd100, 32'h20, 0);
      do_req(11'd50, 32'h21, 1);
      check_state("coincide");
      chk("coincide_cnt", 64'(fq_cnt), 64'd1);

      do_req(11'd0, 32'h30, 0);
      do_req(11'd0, 32'h31, 0);
      do_req(11'd0, 32'h32, 0);
      check_state("len0");

      for (int n = 0; n < 60; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 3) do_rd();
         else if (r < 7) do_req(11'($urandom_range(0, 400)), $urandom, $urandom_range(0, 7) == 0);
         else do_req(11'($urandom_range(0, 2047)), $urandom, 0);
         check_state("rand");
      end
`ifdef RAW_FENCE_DENY_CNT_EN
      chk("deny_cnt", 64'(deny_cnt), 64'(mdeny));
`endif
      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      do_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
